// File: rtl/bus_rd_resp.sv
// Read-response engine: queues AR requests and streams one memory beat per cycle,
// returning beats in acceptance order with gapless back-to-back bursts.
module bus_rd_resp #(
    parameter int unsigned AQ_DEPTH = 2,
    parameter int unsigned ADDR_INC = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        PrbBus_arvalid,
    input  logic [3:0]  PrbBus_arusrid,
    input  logic [3:0]  PrbBus_arlen,
    input  logic        PrbBus_aruserap,
    input  logic [27:0] PrbBus_araddr,
    output logic        BusPrb_arready,
    output logic        BusPrb_rvalid,
    output logic        BusPrb_rlast,
    output logic [3:0]  BusPrb_rid,
    output logic [31:0] BusPrb_rdata,
    output logic        mem_rd_en,
    output logic [27:0] mem_rd_addr,
    input  logic [31:0] mem_rd_data,
    output logic        busy
);

    localparam int unsigned PW = (AQ_DEPTH > 1) ? $clog2(AQ_DEPTH) : 1;
    localparam int unsigned CW = PW + 1;
    localparam logic [27:0]   INC  = 28'(ADDR_INC);
    localparam logic [CW-1:0] FULL = CW'(AQ_DEPTH);

    typedef struct packed {
        logic [3:0]  id;
        logic [3:0]  len;
        logic        ap;
        logic [27:0] addr;
    } aq_entry_t;

    typedef enum logic {IDLE, BURST} state_t;

    aq_entry_t     aq_mem [AQ_DEPTH];
    aq_entry_t     head;
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          aq_nonempty;
    logic          push, pop;

    state_t        state, state_nxt;
    logic          issue, last;
    logic [27:0]   cur_addr;
    logic [3:0]    cur_len, cur_id, beat_cnt;
    logic          cur_ap;

    logic          rvalid_q, rlast_q;
    logic [3:0]    rid_q;

    assign aq_nonempty    = (count != '0);
    assign head           = aq_mem[rd_ptr];
    assign BusPrb_arready = ~rst & (count != FULL);
    assign push           = PrbBus_arvalid & BusPrb_arready;

    always_ff @(posedge clk) begin
        if (push) begin
            aq_mem[wr_ptr] <= {PrbBus_arusrid, PrbBus_arlen, PrbBus_aruserap, PrbBus_araddr};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (aq_nonempty) state_nxt = BURST;
            BURST:   if (last && !aq_nonempty) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // The last beat pops the next entry in the same cycle so bursts run back to back.
    always_comb begin
        issue = 1'b0;
        last  = 1'b0;
        pop   = 1'b0;
        if (state == BURST && !rst) begin
            issue = 1'b1;
            last  = (beat_cnt == cur_len);
        end
        pop = aq_nonempty & ((state == IDLE) | last);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cur_addr <= '0;
            cur_len  <= '0;
            cur_id   <= '0;
            cur_ap   <= 1'b0;
            beat_cnt <= '0;
        end else if (pop) begin
            cur_addr <= head.addr;
            cur_len  <= head.len;
            cur_id   <= head.id;
            cur_ap   <= head.ap;
            beat_cnt <= '0;
        end else if (issue) begin
            beat_cnt <= beat_cnt + 4'd1;
            if (cur_ap) cur_addr <= cur_addr + INC;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rvalid_q <= 1'b0;
            rlast_q  <= 1'b0;
            rid_q    <= '0;
        end else begin
            rvalid_q <= issue;
            rlast_q  <= last;
            rid_q    <= issue ? cur_id : '0;
        end
    end

    assign mem_rd_en     = issue;
    assign mem_rd_addr   = issue ? cur_addr : '0;
    assign BusPrb_rvalid = rvalid_q;
    assign BusPrb_rlast  = rlast_q;
    assign BusPrb_rid    = rid_q;
    assign BusPrb_rdata  = rvalid_q ? mem_rd_data : '0;
    assign busy          = ~rst & (aq_nonempty | (state == BURST) | rvalid_q);

endmodule

// File: tb/tb_bus_rd_resp.sv
// Bench for bus_rd_resp: directed and random AR traffic checked cycle by cycle
// against a timeline model of when each beat must appear.
module tb_bus_rd_resp;

    localparam int unsigned AQ_DEPTH = 2;
    localparam int unsigned ADDR_INC = 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        arvalid = 1'b0;
    logic [3:0]  arid = '0;
    logic [3:0]  arlen = '0;
    logic        ap = 1'b0;
    logic [27:0] araddr = '0;
    logic        BusPrb_arready, BusPrb_rvalid, BusPrb_rlast, mem_rd_en, busy;
    logic [3:0]  BusPrb_rid;
    logic [31:0] BusPrb_rdata;
    logic [27:0] mem_rd_addr;
    logic [31:0] mem_rd_data = '0;

    bus_rd_resp #(.AQ_DEPTH(AQ_DEPTH), .ADDR_INC(ADDR_INC)) dut (
        .clk(clk), .rst(rst),
        .PrbBus_arvalid(arvalid), .PrbBus_arusrid(arid), .PrbBus_arlen(arlen),
        .PrbBus_aruserap(ap), .PrbBus_araddr(araddr),
        .BusPrb_arready(BusPrb_arready), .BusPrb_rvalid(BusPrb_rvalid),
        .BusPrb_rlast(BusPrb_rlast), .BusPrb_rid(BusPrb_rid), .BusPrb_rdata(BusPrb_rdata),
        .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Memory returns its own word address; garbage whenever no read was strobed.
    always @(posedge clk) mem_rd_data <= mem_rd_en ? {4'h0, mem_rd_addr} : $urandom;

    typedef struct {
        int          t;
        logic [3:0]  id;
        logic        last;
        logic [27:0] addr;
    } beat_t;

    beat_t sb[$];
    int    occ[$];
    int    ecount = 0;
    int    last_end = -100;
    int    nvec = 0;
    int    nfail = 0;
    int    beats_seen = 0;
    bit    started = 1'b0;
    bit    accepted = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        assert (got === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h (edge %0d)", tag, got, exp, ecount);
        end
    endtask

    task automatic monitor();
        int    e;
        bit    ev;
        bit    en_exp;
        beat_t b;
        e = ecount;
        while (occ.size() > 0 && occ[0] <= e) void'(occ.pop_front());
        chk("arready", 32'(BusPrb_arready), 32'(!rst && occ.size() < AQ_DEPTH));
        chk("busy", 32'(busy), 32'(!rst && sb.size() > 0));
        ev = (sb.size() > 0) && (sb[0].t == e);
        b.t = 0; b.id = '0; b.last = 1'b0; b.addr = '0;
        if (ev) begin
            b = sb.pop_front();
            beats_seen++;
        end
        chk("rvalid", 32'(BusPrb_rvalid), 32'(ev));
        chk("rlast", 32'(BusPrb_rlast), 32'(ev && b.last));
        chk("rdata", BusPrb_rdata, ev ? {4'h0, b.addr} : 32'h0);
        if (ev) chk("rid", 32'(BusPrb_rid), 32'(b.id));
        else if (rst) chk("rid_rst", 32'(BusPrb_rid), 32'h0);
        en_exp = !rst && sb.size() > 0 && sb[0].t == e + 1;
        chk("mem_rd_en", 32'(mem_rd_en), 32'(en_exp));
        if (en_exp) chk("mem_rd_addr", 32'(mem_rd_addr), {4'h0, sb[0].addr});
        else if (rst) chk("mem_rd_addr_rst", 32'(mem_rd_addr), 32'h0);
    endtask

    // A burst accepted at edge h starts returning at max(h+2, previous end+1).
    task automatic record();
        int    h;
        int    s;
        beat_t b;
        h = ecount + 1;
        s = (last_end + 1 > h + 2) ? last_end + 1 : h + 2;
        for (int i = 0; i <= int'(arlen); i++) begin
            b.t    = s + i;
            b.id   = arid;
            b.last = (i == int'(arlen));
            b.addr = ap ? araddr + 28'(i * int'(ADDR_INC)) : araddr;
            sb.push_back(b);
        end
        occ.push_back(s - 1);
        last_end = s + int'(arlen);
    endtask

    task automatic cyc();
        @(negedge clk);
        if (started) monitor();
        accepted = 1'b0;
        if (arvalid && !rst && occ.size() < AQ_DEPTH) begin
            record();
            accepted = 1'b1;
        end
        @(posedge clk);
        ecount++;
        started = 1'b1;
        if (rst) begin
            sb.delete();
            occ.delete();
            last_end = -100;
        end
        #1;
    endtask

    task automatic send(input logic [3:0] id, input logic [3:0] len,
                        input logic bap, input logic [27:0] addr);
        int n;
        bit got;
        arid = id; arlen = len; ap = bap; araddr = addr; arvalid = 1'b1;
        n = 0; got = 1'b0;
        while (!got && n < 100) begin
            cyc();
            got = accepted;
            n++;
        end
        arvalid = 1'b0;
        chk("send_accept", 32'(got), 32'h1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() > 0 && n < 400) begin
            cyc();
            n++;
        end
        cyc();
        cyc();
        chk("drain", 32'(sb.size()), 32'h0);
    endtask

    initial begin
        int base;
        int n;
        rst = 1'b1;
        repeat (3) cyc();
        rst = 1'b0;
        cyc();

        send(4'd5, 4'd3, 1'b1, 28'h100);
        drain();

        send(4'd9, 4'd2, 1'b0, 28'h20);
        drain();

        send(4'd1, 4'd1, 1'b1, 28'h300);
        send(4'd2, 4'd0, 1'b1, 28'h400);
        drain();

        arid = 4'd7; arlen = 4'd15; ap = 1'b1; araddr = 28'h1000; arvalid = 1'b1;
        repeat (60) cyc();
        arvalid = 1'b0;
        drain();

        send(4'hA, 4'd3, 1'b1, 28'hFFFFFFE);
        drain();

        send(4'd3, 4'd7, 1'b1, 28'h40);
        base = beats_seen;
        n = 0;
        while (beats_seen < base + 2 && n < 50) begin
            cyc();
            n++;
        end
        chk("reset_setup_beats", 32'(beats_seen - base), 32'd2);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        cyc();
        send(4'd4, 4'd2, 1'b1, 28'h80);
        drain();

        for (int k = 0; k < 400; k++) begin
            arvalid = ($urandom_range(0, 2) == 0);
            arid    = 4'($urandom);
            arlen   = 4'($urandom);
            ap      = 1'($urandom);
            araddr  = 28'($urandom);
            rst     = (k == 200);
            cyc();
        end
        arvalid = 1'b0;
        rst = 1'b0;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
